ann_cascade_sequencer: RTL and testbench

ANN_CASCADE_SEQUENCER -- requirements
Module: ann_cascade_sequencer

---
 rtl/ann_cascade_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_ann_cascade_sequencer.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ann_cascade_sequencer.sv
// Cascade-classifier sequencer: walks the configured stages of a neural
// cascade. For each stage it streams the feature beats to the MAC lanes,
// drains the MAC pipeline, requests one activation per hidden neuron and
// then asks the threshold unit for a verdict. A failing verdict rejects the
// window early. A stage whose feature count is zero is skipped.
module ann_cascade_sequencer #(
  parameter int N_MAC     = 20,
  parameter int N_STAGE   = 12,
  parameter int FEAT_W    = 7,
  parameter int ADDR_W    = 10,
  parameter int FLUSH_LAT = 2,
  localparam int LW = $clog2(N_MAC + 1),
  localparam int SW = $clog2(N_STAGE)
) (
  input  logic              iClk,
  input  logic              iReset,
  input  logic              iStart,
  input  logic              iCfg_we,
  input  logic [SW-1:0]     iCfg_stage,
  input  logic [FEAT_W-1:0] iCfg_feat,
  input  logic [LW-1:0]     iCfg_hid,
  output logic              oBusy,
  output logic [FEAT_W-1:0] oFeat_addr,
  output logic [ADDR_W-1:0] oWeight_addr,
  output logic [N_MAC-1:0]  oMac_en,
  output logic              oMac_clear,
  output logic              oMac_last,
  output logic              oAct_req,
  output logic [LW-1:0]     oAct_sel,
  input  logic              iAct_valid,
  output logic              oThr_req,
  input  logic              iThr_valid,
  input  logic              iThr_pass,
  output logic [SW-1:0]     oStage,
  output logic              oDone,
  output logic              oPass
);

  // Flush counter only needs to reach FLUSH_LAT-1.
  localparam int FLW = (FLUSH_LAT > 1) ? $clog2(FLUSH_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEAT,
    S_FLUSH,
    S_HID,
    S_THR,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SW-1:0]       stage_q, stage_d;
  logic [FEAT_W-1:0]   feat_cnt_q, feat_cnt_d;
  logic [LW-1:0]       hid_cnt_q, hid_cnt_d;
  logic [FLW-1:0]      flush_cnt_q, flush_cnt_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic                pass_q, pass_d;

  logic [FEAT_W-1:0]   cfg_feat_q [N_STAGE];
  logic [LW-1:0]       cfg_hid_q  [N_STAGE];

  logic [FEAT_W-1:0]   cur_feat;
  logic [LW-1:0]       cur_hid;
  logic                last_stage;
  logic                beat;
  logic                cfg_stage_ok;

  // Saturate a requested hidden-neuron count to the physical lane count.
  function automatic logic [LW-1:0] hid_clamp(input logic [LW-1:0] h);
    return (h > LW'(N_MAC)) ? LW'(N_MAC) : h;
  endfunction

  // Thermometer mask enabling the lowest h lanes.
  function automatic logic [N_MAC-1:0] lane_mask(input logic [LW-1:0] h);
    logic [N_MAC-1:0] m;
    for (int i = 0; i < N_MAC; i++) begin
      m[i] = (i < int'(h));
    end
    return m;
  endfunction

  assign cur_feat     = cfg_feat_q[stage_q];
  assign cur_hid      = cfg_hid_q[stage_q];
  assign last_stage   = (stage_q == SW'(N_STAGE - 1));
  assign cfg_stage_ok = ({1'b0, iCfg_stage} < (SW + 1)'(N_STAGE));

  // Stage configuration table; only writable while the sequencer is idle.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      for (int s = 0; s < N_STAGE; s++) begin
        cfg_feat_q[s] <= '0;
        cfg_hid_q[s]  <= '0;
      end
    end else if (iCfg_we && (state_q == S_IDLE) && cfg_stage_ok) begin
      cfg_feat_q[iCfg_stage] <= iCfg_feat;
      cfg_hid_q[iCfg_stage]  <= hid_clamp(iCfg_hid);
    end
  end

  // State register together with the stage, beat, lane and address counters.
  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q     <= S_IDLE;
      stage_q     <= '0;
      feat_cnt_q  <= '0;
      hid_cnt_q   <= '0;
      flush_cnt_q <= '0;
      waddr_q     <= '0;
      pass_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      feat_cnt_q  <= feat_cnt_d;
      hid_cnt_q   <= hid_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      waddr_q     <= waddr_d;
      pass_q      <= pass_d;
    end
  end

  // Next-state decisions and all sequencer outputs.
  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    feat_cnt_d  = feat_cnt_q;
    hid_cnt_d   = hid_cnt_q;
    flush_cnt_d = flush_cnt_q;
    waddr_d     = waddr_q;
    pass_d      = pass_q;

    // A FEAT cycle on a stage with no features is a skip, not a beat.
    beat = (state_q == S_FEAT) && (cur_feat != '0);

    unique case (state_q)
      S_IDLE: begin
        if (iStart) begin
          state_d    = S_FEAT;
          stage_d    = '0;
          feat_cnt_d = '0;
          waddr_d    = '0;
          pass_d     = 1'b0;
        end
      end
      S_FEAT: begin
        if (cur_feat == '0) begin
          if (last_stage) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            stage_d = stage_q + 1'b1;
          end
        end else begin
          waddr_d = waddr_q + 1'b1;
          if (feat_cnt_q == cur_feat - 1'b1) begin
            feat_cnt_d  = '0;
            flush_cnt_d = '0;
            state_d     = S_FLUSH;
          end else begin
            feat_cnt_d = feat_cnt_q + 1'b1;
          end
        end
      end
      S_FLUSH: begin
        if (flush_cnt_q == FLW'(FLUSH_LAT - 1)) begin
          hid_cnt_d = '0;
          state_d   = (cur_hid == '0) ? S_THR : S_HID;
        end else begin
          flush_cnt_d = flush_cnt_q + 1'b1;
        end
      end
      S_HID: begin
        if (iAct_valid) begin
          if (hid_cnt_q == cur_hid - 1'b1) begin
            state_d = S_THR;
          end else begin
            hid_cnt_d = hid_cnt_q + 1'b1;
          end
        end
      end
      S_THR: begin
        if (iThr_valid) begin
          if (!iThr_pass) begin
            state_d = S_DONE;
            pass_d  = 1'b0;
          end else if (last_stage) begin
            state_d = S_DONE;
            pass_d  = 1'b1;
          end else begin
            stage_d    = stage_q + 1'b1;
            feat_cnt_d = '0;
            state_d    = S_FEAT;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    oBusy        = (state_q != S_IDLE);
    oFeat_addr   = beat ? feat_cnt_q : '0;
    oWeight_addr = waddr_q;
    oMac_en      = beat ? lane_mask(cur_hid) : '0;
    oMac_clear   = beat && (feat_cnt_q == '0);
    oMac_last    = beat && (feat_cnt_q == cur_feat - 1'b1);
    oAct_req     = (state_q == S_HID);
    oAct_sel     = (state_q == S_HID) ? hid_cnt_q : '0;
    oThr_req     = (state_q == S_THR);
    oStage       = stage_q;
    oDone        = (state_q == S_DONE);
    oPass        = pass_q;
  end

endmodule

// File: tb/tb_ann_cascade_sequencer.sv
// Bench for ann_cascade_sequencer: directed scenario table, a few hand
// sequences (mid-run writes, reset during HID) and randomized windows
// checked against a stage-level reference model.
module tb_ann_cascade_sequencer;

  localparam int N_MAC     = 20;
  localparam int N_STAGE   = 12;
  localparam int FEAT_W    = 7;
  localparam int ADDR_W    = 4;
  localparam int FLUSH_LAT = 2;
  localparam int LW        = 5;
  localparam int SW        = 4;
  localparam int BUDGET    = 4000;

  logic              iClk = 1'b0;
  logic              iReset = 1'b1;
  logic              iStart = 1'b0;
  logic              iCfg_we = 1'b0;
  logic [SW-1:0]     iCfg_stage = '0;
  logic [FEAT_W-1:0] iCfg_feat = '0;
  logic [LW-1:0]     iCfg_hid = '0;
  logic              iAct_valid = 1'b0;
  logic              iThr_valid = 1'b0;
  logic              iThr_pass = 1'b0;
  logic              oBusy, oMac_clear, oMac_last, oAct_req, oThr_req, oDone, oPass;
  logic [FEAT_W-1:0] oFeat_addr;
  logic [ADDR_W-1:0] oWeight_addr;
  logic [N_MAC-1:0]  oMac_en;
  logic [LW-1:0]     oAct_sel;
  logic [SW-1:0]     oStage;

  ann_cascade_sequencer #(
    .N_MAC(N_MAC), .N_STAGE(N_STAGE), .FEAT_W(FEAT_W),
    .ADDR_W(ADDR_W), .FLUSH_LAT(FLUSH_LAT)
  ) dut (
    .iClk(iClk), .iReset(iReset), .iStart(iStart),
    .iCfg_we(iCfg_we), .iCfg_stage(iCfg_stage), .iCfg_feat(iCfg_feat), .iCfg_hid(iCfg_hid),
    .oBusy(oBusy), .oFeat_addr(oFeat_addr), .oWeight_addr(oWeight_addr),
    .oMac_en(oMac_en), .oMac_clear(oMac_clear), .oMac_last(oMac_last),
    .oAct_req(oAct_req), .oAct_sel(oAct_sel), .iAct_valid(iAct_valid),
    .oThr_req(oThr_req), .iThr_valid(iThr_valid), .iThr_pass(iThr_pass),
    .oStage(oStage), .oDone(oDone), .oPass(oPass)
  );

  always #5 iClk = ~iClk;

  int checks = 0;
  int errors = 0;

  // Bench copy of the stage table and the verdict each stage will receive.
  int cfg_feat [N_STAGE];
  int cfg_hid  [N_STAGE];
  bit thr_ok   [N_STAGE];

  typedef struct packed {
    logic [SW-1:0]     stage;
    logic [FEAT_W-1:0] k;
    logic [ADDR_W-1:0] waddr;
    logic [N_MAC-1:0]  mask;
    logic              clear;
    logic              last;
  } beat_t;

  typedef struct packed {
    logic [SW-1:0] stage;
    logic [LW-1:0] sel;
    logic [7:0]    delay;
  } hs_t;

  beat_t exp_beats [$];
  hs_t   exp_acts  [$];
  hs_t   exp_thrs  [$];

  typedef struct {
    int f0, h0, f1, h1, f2, h2;
    int fail_at;
    bit pass;
    int stage;
    int beats;
    int acts;
    int waddr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] outs_all();
    return {oBusy, oFeat_addr, oWeight_addr, oMac_en, oMac_clear, oMac_last,
            oAct_req, oAct_sel, oThr_req, oStage, oDone, oPass};
  endfunction

  task automatic clear_cfg_copy();
    for (int s = 0; s < N_STAGE; s++) begin
      cfg_feat[s] = 0;
      cfg_hid[s]  = 0;
    end
  endtask

  task automatic write_cfg(input int s, input int f, input int h);
    iCfg_we    = 1'b1;
    iCfg_stage = SW'(s);
    iCfg_feat  = FEAT_W'(f);
    iCfg_hid   = LW'(h);
    @(negedge iClk);
    iCfg_we = 1'b0;
    if (s < N_STAGE) begin
      cfg_feat[s] = f;
      cfg_hid[s]  = (h > N_MAC) ? N_MAC : h;
    end
  endtask

  task automatic write_all();
    for (int s = 0; s < N_STAGE; s++) write_cfg(s, cfg_feat[s], cfg_hid[s]);
  endtask

  // Stage-level model: beats, handshakes, verdict, final stage and latency.
  task automatic build_model(input int dmax, output bit pass, output int stage,
                             output int cyc, output bit det, output int waddr);
    int s, addr, d, f, h;
    bit fin;
    beat_t b;
    hs_t hs;
    exp_beats.delete();
    exp_acts.delete();
    exp_thrs.delete();
    s = 0; addr = 0; fin = 0; cyc = 1; det = 1; pass = 0;
    while (!fin) begin
      f = cfg_feat[s];
      h = cfg_hid[s];
      if (f == 0) begin
        det = 0;
        if (s == N_STAGE - 1) begin pass = 1; fin = 1; end
        else s++;
      end else begin
        for (int k = 0; k < f; k++) begin
          b.stage = SW'(s);
          b.k     = FEAT_W'(k);
          b.waddr = ADDR_W'(addr);
          b.mask  = N_MAC'((1 << h) - 1);
          b.clear = (k == 0);
          b.last  = (k == f - 1);
          if (h > 0) exp_beats.push_back(b);
          addr = (addr + 1) % (1 << ADDR_W);
        end
        cyc += f + FLUSH_LAT;
        for (int j = 0; j < h; j++) begin
          d = int'($urandom_range(0, dmax));
          hs.stage = SW'(s); hs.sel = LW'(j); hs.delay = 8'(d);
          exp_acts.push_back(hs);
          cyc += d + 1;
        end
        d = int'($urandom_range(0, dmax));
        hs.stage = SW'(s); hs.sel = LW'(thr_ok[s]); hs.delay = 8'(d);
        exp_thrs.push_back(hs);
        cyc += d + 1;
        if (!thr_ok[s]) begin pass = 0; fin = 1; end
        else if (s == N_STAGE - 1) begin pass = 1; fin = 1; end
        else s++;
      end
    end
    stage = s;
    waddr = addr;
    cyc += 1;
  endtask

  // Runs one window starting at the current negedge (sequencer idle).
  task automatic run_window(input int dmax, input bit inject, input int abort_stage,
                            output bit o_pass, output int o_stage, output int o_beats,
                            output int o_acts, output int o_waddr);
    bit exp_pass, det, done, aborted, act_busy, thr_busy;
    int exp_stage, exp_cyc, exp_waddr, act_wait, thr_wait, n, o_thrs;
    int tot_beats, tot_acts, tot_thrs;
    beat_t eb;
    hs_t ha, ht;
    build_model(dmax, exp_pass, exp_stage, exp_cyc, det, exp_waddr);
    tot_beats = exp_beats.size();
    tot_acts  = exp_acts.size();
    tot_thrs  = exp_thrs.size();
    o_beats = 0; o_acts = 0; o_thrs = 0; done = 0; aborted = 0;
    act_busy = 0; thr_busy = 0; act_wait = 0; thr_wait = 0; n = 0;
    ha = '0; ht = '0;
    iStart = 1'b1;
    while (!done && n < BUDGET) begin
      @(negedge iClk);
      n++;
      iStart  = 1'b0;
      iCfg_we = 1'b0;
      if (inject && n == 2) begin
        iStart = 1'b1; iCfg_we = 1'b1; iCfg_stage = '0; iCfg_feat = 7'd1; iCfg_hid = 5'd1;
      end
      if (oMac_en != '0) begin
        o_beats++;
        if (exp_beats.size() == 0) chk("beat_extra", o_beats, tot_beats);
        else begin
          eb = exp_beats.pop_front();
          chk("beat", {oStage, oFeat_addr, oWeight_addr, oMac_en, oMac_clear, oMac_last}, eb);
        end
      end
      if (abort_stage >= 0 && oAct_req && oStage == SW'(abort_stage)) begin
        iReset = 1'b1; iAct_valid = 1'b0; iThr_valid = 1'b0; iThr_pass = 1'b0;
        #1;
        chk("reset_async_outputs", outs_all(), 64'd0);
        @(negedge iClk);
        chk("reset_held_outputs", outs_all(), 64'd0);
        iReset = 1'b0;
        clear_cfg_copy();
        aborted = 1; done = 1;
      end else begin
        if (oAct_req) begin
          if (!act_busy) begin
            act_busy = 1; o_acts++;
            if (exp_acts.size() == 0) begin
              chk("act_extra", o_acts, tot_acts);
              act_wait = 0;
            end else begin
              ha = exp_acts.pop_front();
              chk("act_req", {oStage, oAct_sel}, {ha.stage, ha.sel});
              act_wait = int'(ha.delay);
            end
          end
          if (act_wait == 0) begin iAct_valid = 1'b1; act_busy = 0; end
          else begin act_wait--; iAct_valid = 1'b0; end
        end else begin
          iAct_valid = 1'($urandom_range(0, 1));
        end
        if (oThr_req) begin
          if (!thr_busy) begin
            thr_busy = 1; o_thrs++;
            if (exp_thrs.size() == 0) begin
              chk("thr_extra", o_thrs, tot_thrs);
              thr_wait = 0;
            end else begin
              ht = exp_thrs.pop_front();
              chk("thr_req_stage", oStage, ht.stage);
              thr_wait = int'(ht.delay);
            end
          end
          if (thr_wait == 0) begin iThr_valid = 1'b1; iThr_pass = ht.sel[0]; thr_busy = 0; end
          else begin thr_wait--; iThr_valid = 1'b0; iThr_pass = 1'($urandom_range(0, 1)); end
        end else begin
          iThr_valid = 1'($urandom_range(0, 1));
          iThr_pass  = 1'($urandom_range(0, 1));
        end
        if (oDone) done = 1;
      end
    end
    iAct_valid = 1'b0; iThr_valid = 1'b0; iThr_pass = 1'b0;
    o_pass  = oPass;
    o_stage = int'(oStage);
    o_waddr = int'(oWeight_addr);
    if (!done) begin
      checks++; errors++;
      $display("FAIL timeout: no oDone within %0d cycles", BUDGET);
      iReset = 1'b1;
      @(negedge iClk);
      iReset = 1'b0;
      clear_cfg_copy();
    end else if (!aborted) begin
      chk("pass", oPass, exp_pass);
      chk("final_stage", oStage, exp_stage);
      if (det) chk("latency", n + 1, exp_cyc);
      chk("waddr_end", oWeight_addr, exp_waddr);
      chk("beats_missing", exp_beats.size(), 0);
      chk("acts_missing", exp_acts.size(), 0);
      chk("thrs_missing", exp_thrs.size(), 0);
      @(negedge iClk);
      chk("done_one_cycle", {oDone, oBusy, oPass}, {1'b0, 1'b0, exp_pass});
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit p;
    int st, nb, na, wa, mode;

    vecs[0] = '{3, 2,  0, 0,  0, 0, -1, 1'b1, 11,  3,  2, 3};
    vecs[1] = '{4, 20, 5, 10, 0, 0,  0, 1'b0,  0,  4, 20, 4};
    vecs[2] = '{0, 0,  2, 25, 0, 0, -1, 1'b1, 11,  2, 20, 2};
    vecs[3] = '{5, 3,  6, 1,  9, 4, -1, 1'b1, 11, 20,  8, 4};
    vecs[4] = '{2, 0,  1, 1,  0, 0, -1, 1'b1, 11,  1,  1, 3};
    vecs[5] = '{1, 1,  1, 1,  1, 1,  2, 1'b0,  2,  3,  3, 3};
    vecs[6] = '{0, 0,  0, 0,  0, 0, -1, 1'b1, 11,  0,  0, 0};

    clear_cfg_copy();
    repeat (2) @(negedge iClk);
    chk("reset_outputs", outs_all(), 64'd0);
    iReset = 1'b0;

    // Directed scenario table.
    for (int v = 0; v < 7; v++) begin
      for (int s = 0; s < N_STAGE; s++) begin
        cfg_feat[s] = 0; cfg_hid[s] = 0; thr_ok[s] = (s != vecs[v].fail_at);
      end
      cfg_feat[0] = vecs[v].f0; cfg_hid[0] = vecs[v].h0;
      cfg_feat[1] = vecs[v].f1; cfg_hid[1] = vecs[v].h1;
      cfg_feat[2] = vecs[v].f2; cfg_hid[2] = vecs[v].h2;
      write_all();
      run_window(0, 1'b0, -1, p, st, nb, na, wa);
      chk($sformatf("vec%0d_pass", v), p, vecs[v].pass);
      chk($sformatf("vec%0d_stage", v), st, vecs[v].stage);
      chk($sformatf("vec%0d_beats", v), nb, vecs[v].beats);
      chk($sformatf("vec%0d_acts", v), na, vecs[v].acts);
      chk($sformatf("vec%0d_waddr", v), wa, vecs[v].waddr);
    end

    // Config write and iStart while streaming features are both dropped.
    clear_cfg_copy();
    for (int s = 0; s < N_STAGE; s++) thr_ok[s] = 1'b1;
    cfg_feat[0] = 6; cfg_hid[0] = 3;
    write_all();
    run_window(1, 1'b1, -1, p, st, nb, na, wa);
    chk("busy_write_beats", nb, 6);
    run_window(1, 1'b0, -1, p, st, nb, na, wa);
    chk("table_unchanged_beats", nb, 6);
    chk("table_unchanged_acts", na, 3);

    // Reset during HID of stage 3, then an empty-table window.
    clear_cfg_copy();
    for (int s = 0; s < 4; s++) begin cfg_feat[s] = 1; cfg_hid[s] = 2; end
    write_all();
    run_window(0, 1'b0, 3, p, st, nb, na, wa);
    run_window(0, 1'b0, -1, p, st, nb, na, wa);
    chk("after_reset_pass", p, 1'b1);
    chk("after_reset_stage", st, 11);
    chk("after_reset_beats", nb, 0);

    // Out-of-range stage write is dropped.
    write_cfg(12, 3, 3);
    run_window(0, 1'b0, -1, p, st, nb, na, wa);
    chk("oob_write_beats", nb, 0);

    // Randomized windows against the model.
    for (int r = 0; r < 30; r++) begin
      mode = int'($urandom_range(0, 1));
      for (int s = 0; s < N_STAGE; s++) begin
        if (mode == 1) cfg_feat[s] = int'($urandom_range(1, 4));
        else cfg_feat[s] = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0;
        cfg_hid[s] = int'($urandom_range(0, 24));
        thr_ok[s]  = ($urandom_range(0, 99) < 85);
      end
      write_all();
      run_window(2, 1'b0, -1, p, st, nb, na, wa);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
